// File: rtl/dis_pkg.sv
// Shared types and constants for the dis register arbiter slice.
package dis_pkg;
   localparam int DIS_DW    = 8;
   localparam int DIS_GAP_W = 4;

   typedef enum logic [1:0] {IDLE, WRITE, SETTLE} dis_arb_state_t;
endpackage

// File: rtl/dis_arbiter_if.sv
// Requester handshake plus the register-side outputs of dis_arbiter.
interface dis_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 8
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*DW-1:0]      req_data;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       reg_en;
   logic [DW-1:0]              reg_data;
   logic [$clog2(NUM_REQ)-1:0] owner;
   logic                       busy;

   modport master (output req_valid, req_data,
                   input  req_ready, reg_en, reg_data, owner, busy);
   modport slave  (input  req_valid, req_data,
                   output req_ready, reg_en, reg_data, owner, busy);
endinterface

// File: rtl/dis_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      idx = '0;
      any = |req;
      // Walk from the farthest slot back toward ptr so the closest requester is written last.
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
      end
      grant = any ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/dis_arbiter.sv
// Round-robin arbiter and one-shot write sequencer in front of the dis register,
// with a programmable settle gap between writes.
module dis_arbiter
   import dis_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DW      = DIS_DW,
   parameter int GAP     = 1
) (
   input logic          clk,
   input logic          reset,
   dis_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [DIS_GAP_W-1:0] GAP_LOAD = (GAP > 0) ? DIS_GAP_W'(GAP - 1) : '0;

   dis_arb_state_t        state, state_n;
   logic [DIS_GAP_W-1:0]  gap_cnt;
   logic [IW-1:0]         rr_ptr;
   logic [NUM_REQ-1:0]    grant;
   logic [IW-1:0]         win_idx;
   logic                  win_any;
   logic                  accept;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   assign accept        = (state == IDLE) && win_any;
   assign bus.req_ready = accept ? grant : '0;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (win_any) state_n = WRITE;
         WRITE:   state_n = (GAP > 0) ? SETTLE : IDLE;
         SETTLE:  if (gap_cnt == '0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (reset) begin
         state        <= IDLE;
         gap_cnt      <= '0;
         rr_ptr       <= '0;
         bus.reg_en   <= 1'b0;
         bus.reg_data <= '0;
         bus.owner    <= '0;
         bus.busy     <= 1'b0;
      end else begin
         state      <= state_n;
         bus.reg_en <= (state_n == WRITE);
         bus.busy   <= (state_n != IDLE);
         if (accept) begin
            bus.reg_data <= bus.req_data[int'(win_idx)*DW +: DW];
            bus.owner    <= win_idx;
            rr_ptr       <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
         end
         // Counter is loaded while writing so SETTLE sees GAP-1 on its first cycle.
         if (state == WRITE)
            gap_cnt <= GAP_LOAD;
         else if (state == SETTLE && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_dis_arbiter.sv
// Directed bench for dis_arbiter: one GAP=1 instance with a dis register model,
// one GAP=0 instance for back-to-back throughput.
module tb_dis_arbiter;
   logic       clk = 1'b0;
   logic       rst_a;
   logic       rst_b;
   logic [7:0] dis_q;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   dis_arbiter_if #(.NUM_REQ(4), .DW(8)) a_if ();
   dis_arbiter_if #(.NUM_REQ(4), .DW(8)) b_if ();

   dis_arbiter #(.NUM_REQ(4), .DW(8), .GAP(1)) dut_a (.clk(clk), .reset(rst_a), .bus(a_if.slave));
   dis_arbiter #(.NUM_REQ(4), .DW(8), .GAP(0)) dut_b (.clk(clk), .reset(rst_b), .bus(b_if.slave));

   // Model of the downstream dis register.
   always_ff @(posedge clk) begin
      if (rst_a)            dis_q <= 8'h00;
      else if (a_if.reg_en) dis_q <= a_if.reg_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full GAP=1 grant starting in IDLE with inputs already applied.
   task automatic grant_cycle(input int idx, input logic [7:0] data, input logic [3:0] next_valid);
      #1;
      check("ready_onehot", a_if.req_ready, 32'(4'b0001 << idx));
      step();
      a_if.req_valid = next_valid;
      check("write_en",    a_if.reg_en, 1);
      check("write_data",  a_if.reg_data, data);
      check("write_owner", a_if.owner, idx);
      check("write_busy",  a_if.busy, 1);
      check("write_ready", a_if.req_ready, 0);
      step();
      check("settle_en",    a_if.reg_en, 0);
      check("settle_busy",  a_if.busy, 1);
      check("settle_ready", a_if.req_ready, 0);
      check("dis_out",      dis_q, data);
      step();
      check("idle_busy", a_if.busy, 0);
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      a_if.req_valid = '0;
      a_if.req_data  = '0;
      b_if.req_valid = '0;
      b_if.req_data  = '0;
      step();
      step();
      check("rst_en",    a_if.reg_en, 0);
      check("rst_data",  a_if.reg_data, 0);
      check("rst_owner", a_if.owner, 0);
      check("rst_busy",  a_if.busy, 0);
      rst_a = 1'b0;
      #1;
      check("rst_ready", a_if.req_ready, 0);

      // Single requester
      a_if.req_data  = 32'hA3A2A155;
      a_if.req_valid = 4'b0001;
      grant_cycle(0, 8'h55, 4'b0000);

      // Round-robin fairness from a fresh pointer, then wrap and lone requester
      rst_a = 1'b1;
      step();
      step();
      rst_a = 1'b0;
      a_if.req_data  = 32'hA3A2A1A0;
      a_if.req_valid = 4'b1111;
      grant_cycle(0, 8'hA0, 4'b1111);
      grant_cycle(1, 8'hA1, 4'b1111);
      grant_cycle(2, 8'hA2, 4'b1111);
      grant_cycle(3, 8'hA3, 4'b0101);
      grant_cycle(0, 8'hA0, 4'b0101);
      grant_cycle(2, 8'hA2, 4'b0001);
      grant_cycle(0, 8'hA0, 4'b0001);
      grant_cycle(0, 8'hA0, 4'b0000);

      // Idle with last written value F0
      a_if.req_data  = 32'hA3A2A1F0;
      a_if.req_valid = 4'b0001;
      grant_cycle(0, 8'hF0, 4'b0000);
      for (int i = 0; i < 10; i++) begin
         check("idle_ready", a_if.req_ready, 0);
         check("idle_en",    a_if.reg_en, 0);
         check("idle_hold",  a_if.reg_data, 8'hF0);
         step();
      end

      // Reset during WRITE of 99 from requester 1 (pointer is 1 here)
      a_if.req_data  = 32'hA3A299F0;
      a_if.req_valid = 4'b0010;
      #1;
      check("abort_ready", a_if.req_ready, 4'b0010);
      step();
      a_if.req_valid = 4'b0000;
      rst_a = 1'b1;
      check("abort_pre_en",   a_if.reg_en, 1);
      check("abort_pre_data", a_if.reg_data, 8'h99);
      step();
      rst_a = 1'b0;
      check("abort_en",    a_if.reg_en, 0);
      check("abort_data",  a_if.reg_data, 0);
      check("abort_busy",  a_if.busy, 0);
      check("abort_owner", a_if.owner, 0);
      step();
      check("abort_dis", dis_q, 0);
      a_if.req_valid = 4'b1111;
      grant_cycle(0, 8'hF0, 4'b0000);

      // Reset in the same cycle as a handshake: no capture, pointer stays 0
      a_if.req_data  = 32'hA37799F0;
      a_if.req_valid = 4'b0100;
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      a_if.req_valid = 4'b0000;
      check("rsths_busy", a_if.busy, 0);
      check("rsths_en",   a_if.reg_en, 0);
      check("rsths_data", a_if.reg_data, 0);
      a_if.req_valid = 4'b1001;
      grant_cycle(0, 8'hF0, 4'b0000);

      // GAP=0: back-to-back grants every two cycles
      rst_b = 1'b0;
      b_if.req_data  = 32'h00002211;
      b_if.req_valid = 4'b0011;
      #1;
      check("g0_ready0", b_if.req_ready, 4'b0001);
      step();
      check("g0_en0",    b_if.reg_en, 1);
      check("g0_data0",  b_if.reg_data, 8'h11);
      check("g0_owner0", b_if.owner, 0);
      check("g0_busy0",  b_if.busy, 1);
      check("g0_rdyw0",  b_if.req_ready, 0);
      step();
      check("g0_idle_en0",   b_if.reg_en, 0);
      check("g0_idle_busy0", b_if.busy, 0);
      check("g0_ready1",     b_if.req_ready, 4'b0010);
      step();
      check("g0_en1",    b_if.reg_en, 1);
      check("g0_data1",  b_if.reg_data, 8'h22);
      check("g0_owner1", b_if.owner, 1);
      check("g0_busy1",  b_if.busy, 1);
      step();
      check("g0_idle_en1",   b_if.reg_en, 0);
      check("g0_idle_busy1", b_if.busy, 0);
      check("g0_ready2",     b_if.req_ready, 4'b0001);
      step();
      check("g0_en2",    b_if.reg_en, 1);
      check("g0_owner2", b_if.owner, 0);
      b_if.req_valid = 4'b0000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dis_arbiter.md
# dis_arbiter

Round-robin arbiter and write sequencer that shares the 8-bit enable-gated `dis` data register between several requesters. It accepts one word per grant over a valid/ready handshake, drives the register's `en`/`data_in` pair for exactly one cycle, then enforces a programmable settle gap before the next grant. It sits directly in front of `dis`, and both blocks share the same `clk`/`reset`.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `DW`, default 8: data width, matching the `dis` register width.
- `GAP`, default 1: idle settle cycles after each register write, legal range 0..15.
- `clk` input, 1 bit: the single clock; all logic is rising-edge.
- `reset` input, 1 bit: synchronous, active-high; sampled only on the rising edge of `clk`.
- `req_valid` input, NUM_REQ bits: per-requester request.
- `req_data` input, NUM_REQ*DW bits: flattened payloads; requester i occupies bits [i*DW +: DW].
- `req_ready` output, NUM_REQ bits: combinational, at most one bit high; the transfer occurs when valid and ready are both high.
- `reg_en` output, 1 bit: registered; drives `dis.en`.
- `reg_data` output, DW bits: registered; drives `dis.data_in`.
- `owner` output, $clog2(NUM_REQ) bits: registered; index of the last accepted requester.
- `busy` output, 1 bit: registered; high whenever state is not IDLE.

## Operation
- FSM has three states: IDLE, WRITE, SETTLE.
- IDLE:
  - If any `req_valid` is high, the winner is the first requester at or after `rr_ptr`, searching upward and wrapping modulo NUM_REQ.
  - `req_ready[winner]` is asserted in the same cycle.
  - On that edge, the winner's data is captured into `reg_data`, `owner` is set to the winner, `rr_ptr` is set to (winner+1) mod NUM_REQ, and the FSM moves to WRITE.
  - If no `req_valid` is high, the FSM holds and `req_ready` stays 0.
- WRITE:
  - `reg_en` is 1 for exactly this cycle.
  - Next state is SETTLE if GAP>0, otherwise IDLE.
- SETTLE:
  - The gap counter loads GAP-1 on entry and decrements each cycle.
  - The FSM returns to IDLE on the cycle after the counter reads 0.
  - `reg_en` is 0 throughout.
- `req_ready` is 0 in WRITE and SETTLE. Requesters hold `req_valid`/`req_data` stable until accepted; the arbiter never drops a pending request.
- `reg_data` holds its last value outside WRITE; it is not cleared.
- If the only requester is the one just served, it wins again after the gap (no starvation of a lone requester).
- Reset values: state IDLE, `reg_en`=0, `reg_data`=0, `owner`=0, `busy`=0, `rr_ptr`=0, gap counter 0.
- Reset asserted mid-operation (in WRITE or SETTLE) aborts immediately. Any suppressed write is lost and is not re-acknowledged; the requester has already seen its ready.
- Reset asserted in the same cycle as a handshake: reset wins, no capture occurs, `rr_ptr` stays 0. The requester observed ready, so the team rule is that requesters qualify ready with `!reset`.

## Timing
- Accept at edge T. `reg_en`/`reg_data` are valid during cycle T+1, and `dis.data_out` updates at the end of T+1.
- Grant period is 2+GAP cycles. Maximum throughput is one word per 2+GAP cycles.
- `busy` rises the cycle after accept. It falls on the cycle state returns to IDLE, which is also the cycle the next acceptance can occur.
- No combinational path exists from `req_*` to `reg_*`. The only combinational path is `req_valid` -> `req_ready`.

## Structure
- Shared package `dis_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, WRITE, SETTLE} dis_arb_state_t`
  - the `DIS_DW=8` constant
  - a `DIS_GAP_W=4` constant for the counter width.
- One sub-module, `rr_pick`: a purely combinational round-robin priority picker. It takes `req` and `ptr` and returns a one-hot grant plus an index, and is reusable elsewhere.
- The FSM, gap counter and output registers live in `dis_arbiter`.

## Test plan
- **Single requester:** reset 2 cycles, then `req_valid`=4'b0001 and req0 data 8'h55 → `req_ready[0]` high in that cycle; `reg_en`=1 with `reg_data`=8'h55 and `owner`=0 one cycle later; `dis.data_out`=8'h55 the following cycle.
- **Round-robin fairness:** all four requesters valid continuously with data 8'hA0..8'hA3, GAP=1 → grants in order 0,1,2,3,0, each 3 cycles apart; `reg_en` pulses are exactly 1 cycle wide.
- **Pointer wrap:** last winner 3, then `req_valid`=4'b0101 → requester 0 wins before requester 2.
- **GAP=0:** two requesters valid → `reg_en` pulses every 2 cycles and `busy` toggles 1,0.
- **Reset mid-operation:** reset asserted during WRITE for data 8'h99 → next cycle `reg_en`=0, `reg_data`=0, `busy`=0, `rr_ptr`=0; `dis.data_out` must not show 8'h99.
- **Idle/back-pressure:** `req_valid`=0 for 10 cycles → `req_ready`=0, `reg_en`=0 throughout, and `reg_data` keeps its last value (8'hF0).
